// File: rtl/proc_pkg.sv
// Shared definitions for the multi-cycle processor (control unit and datapath).
// Holds the opcode encodings (which double as ULA operation codes), the bus
// multiplexer selects, the default datapath width and a helper that tells
// which codes the ULA implements.
package proc_pkg;

  localparam int unsigned DATA_W_DEFAULT = 10;

  // Instruction opcodes; the arithmetic/logic ones are also ULA_control codes.
  localparam logic [3:0] LD   = 4'b0000;
  localparam logic [3:0] ST   = 4'b0001;
  localparam logic [3:0] MVNZ = 4'b0010;
  localparam logic [3:0] MV   = 4'b0011;
  localparam logic [3:0] MVI  = 4'b0100;
  localparam logic [3:0] ADD  = 4'b0101;
  localparam logic [3:0] SUB  = 4'b0110;
  localparam logic [3:0] OR   = 4'b0111;
  localparam logic [3:0] SLT  = 4'b1000;
  localparam logic [3:0] SLL  = 4'b1001;
  localparam logic [3:0] SRL  = 4'b1010;

  // Bus multiplexer selects.
  localparam logic [1:0] SEL_DIN = 2'b00;
  localparam logic [1:0] SEL_REG = 2'b01;
  localparam logic [1:0] SEL_PC  = 2'b10;
  localparam logic [1:0] SEL_G   = 2'b11;

  function automatic logic is_ula_op(input logic [3:0] op);
    return op inside {ADD, SUB, OR, SLT, SLL, SRL};
  endfunction

endpackage

// File: rtl/ula.sv
// Combinational ULA of the datapath.
// Ports:
//   a_i           left operand (register A)
//   b_i           right operand (bus value)
//   ula_control_i operation code (opcode encoding)
//   result_o      operation result, modulo 2^Width; 0 for unsupported codes
//   op_valid_o    high when ula_control_i is an implemented operation
module ula
  import proc_pkg::*;
#(
  parameter int unsigned Width = DATA_W_DEFAULT
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [3:0]       ula_control_i,
  output logic [Width-1:0] result_o,
  output logic             op_valid_o
);

  always_comb begin
    result_o   = '0;
    op_valid_o = is_ula_op(ula_control_i);
    case (ula_control_i)
      ADD: result_o = a_i + b_i;
      SUB: result_o = a_i - b_i;
      OR:  result_o = a_i | b_i;
      // Shift by the full B value: any amount >= Width shifts everything out.
      SRL: result_o = a_i >> b_i;
      SLL: result_o = a_i << b_i;
      SLT: result_o = {{(Width-1){1'b0}}, (a_i < b_i)};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/datapath.sv
// Register-transfer datapath of the multi-cycle processor.
// Executes the register transfers strobed by the control unit each cycle.
// Ports:
//   clock, reset          clock and synchronous active-high reset
//   DIN                   memory read data
//   IR_in .. PC_in        load / increment strobes from the control unit
//   mux_control           bus source select (DIN, register, PC, G)
//   register_out          register driven onto the bus (7 drives 0)
//   register_in           load enables for R0..R6
//   ULA_control           ULA operation
//   IR, ADDR, DOUT, W     instruction register, memory address/data/write enable
//   G_or                  OR-reduction of G
//   BusWires              current bus value
module datapath
  import proc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] DIN,
  input  logic              IR_in,
  input  logic              ADDR_in,
  input  logic              DOUT_in,
  input  logic              W_D,
  input  logic              G_in,
  input  logic              A_in,
  input  logic              incr_PC,
  input  logic              PC_in,
  input  logic [1:0]        mux_control,
  input  logic [2:0]        register_out,
  input  logic [6:0]        register_in,
  input  logic [3:0]        ULA_control,
  output logic [DATA_W-1:0] IR,
  output logic              G_or,
  output logic [DATA_W-1:0] ADDR,
  output logic [DATA_W-1:0] DOUT,
  output logic              W,
  output logic [DATA_W-1:0] BusWires
);

  localparam int unsigned NumRegs = 7;

  logic [DATA_W-1:0] r_q [NumRegs];
  logic [DATA_W-1:0] r_d [NumRegs];
  logic [DATA_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] g_q, g_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              w_q, w_d;

  logic [DATA_W-1:0] reg_bus;
  logic [DATA_W-1:0] ula_result;
  logic              ula_op_valid;

  // Register read port; index 7 has no register behind it and reads as 0.
  always_comb begin
    reg_bus = '0;
    for (int i = 0; i < NumRegs; i++) begin
      if (register_out == 3'(i)) reg_bus = r_q[i];
    end
  end

  always_comb begin
    BusWires = '0;
    unique case (mux_control)
      SEL_DIN: BusWires = DIN;
      SEL_REG: BusWires = reg_bus;
      SEL_PC:  BusWires = pc_q;
      SEL_G:   BusWires = g_q;
      default: BusWires = '0;
    endcase
  end

  ula #(
    .Width (DATA_W)
  ) u_ula (
    .a_i           (a_q),
    .b_i           (BusWires),
    .ula_control_i (ULA_control),
    .result_o      (ula_result),
    .op_valid_o    (ula_op_valid)
  );

  always_comb begin
    for (int i = 0; i < NumRegs; i++) begin
      r_d[i] = register_in[i] ? BusWires : r_q[i];
    end
    a_d    = A_in    ? BusWires : a_q;
    addr_d = ADDR_in ? BusWires : addr_q;
    dout_d = DOUT_in ? BusWires : dout_q;
    ir_d   = IR_in   ? DIN      : ir_q;
    w_d    = W_D;

    // A direct load beats the increment.
    pc_d = pc_q;
    if (PC_in) begin
      pc_d = BusWires;
    end else if (incr_PC) begin
      pc_d = pc_q + 1'b1;
    end

    // A valid op always captures; G_in with an unknown code captures the ULA's 0.
    g_d = g_q;
    if (G_in || ula_op_valid) g_d = ula_result;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) r_q[i] <= '0;
      pc_q   <= '0;
      ir_q   <= '0;
      a_q    <= '0;
      g_q    <= '0;
      addr_q <= '0;
      dout_q <= '0;
      w_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NumRegs; i++) r_q[i] <= r_d[i];
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      a_q    <= a_d;
      g_q    <= g_d;
      addr_q <= addr_d;
      dout_q <= dout_d;
      w_q    <= w_d;
    end
  end

  assign IR   = ir_q;
  assign ADDR = addr_q;
  assign DOUT = dout_q;
  assign W    = w_q;
  assign G_or = |g_q;

endmodule

// File: tb/tb_datapath.sv
// Directed, table-driven bench for datapath: hand-written transfer sequences
// plus a table of ULA operand/opcode vectors with precomputed results.
module tb_datapath;
  import proc_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] DIN;
  logic       IR_in, ADDR_in, DOUT_in, W_D, G_in, A_in, incr_PC, PC_in;
  logic [1:0] mux_control;
  logic [2:0] register_out;
  logic [6:0] register_in;
  logic [3:0] ULA_control;
  logic [9:0] IR, ADDR, DOUT, BusWires;
  logic       G_or, W;

  int checks = 0;
  int errors = 0;

  datapath #(.DATA_W(10)) dut (
    .clock        (clock),
    .reset        (reset),
    .DIN          (DIN),
    .IR_in        (IR_in),
    .ADDR_in      (ADDR_in),
    .DOUT_in      (DOUT_in),
    .W_D          (W_D),
    .G_in         (G_in),
    .A_in         (A_in),
    .incr_PC      (incr_PC),
    .PC_in        (PC_in),
    .mux_control  (mux_control),
    .register_out (register_out),
    .register_in  (register_in),
    .ULA_control  (ULA_control),
    .IR           (IR),
    .G_or         (G_or),
    .ADDR         (ADDR),
    .DOUT         (DOUT),
    .W            (W),
    .BusWires     (BusWires)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [9:0] a;
    logic [9:0] b;
    logic [3:0] op;
    logic       g_in;
    logic [9:0] exp_g;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clr();
    IR_in = 0; ADDR_in = 0; DOUT_in = 0; W_D = 0; G_in = 0; A_in = 0;
    incr_PC = 0; PC_in = 0; mux_control = SEL_DIN; register_out = 0;
    register_in = 0; ULA_control = 4'b1111;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic load_reg(input int idx, input logic [9:0] val);
    clr();
    mux_control = SEL_DIN; DIN = val; register_in = 7'(1 << idx);
    step();
    clr();
  endtask

  task automatic read_reg(input string name, input logic [2:0] idx, input logic [9:0] exp);
    clr();
    mux_control = SEL_REG; register_out = idx;
    #1;
    chk(name, BusWires, exp);
  endtask

  task automatic read_sel(input string name, input logic [1:0] sel, input logic [9:0] exp);
    clr();
    mux_control = sel;
    #1;
    chk(name, BusWires, exp);
  endtask

  initial begin
    vecs[0]  = '{10'h007, 10'h005, SUB, 1'b1, 10'h002};
    vecs[1]  = '{10'h003, 10'h3FF, SLT, 1'b1, 10'h001};
    vecs[2]  = '{10'h001, 10'h009, SLL, 1'b0, 10'h200};
    vecs[3]  = '{10'h200, 10'h00A, SRL, 1'b1, 10'h000};
    vecs[4]  = '{10'h3FF, 10'h002, ADD, 1'b1, 10'h001};
    vecs[5]  = '{10'h155, 10'h0AA, OR,  1'b1, 10'h1FF};
    vecs[6]  = '{10'h200, 10'h003, SRL, 1'b1, 10'h040};
    vecs[7]  = '{10'h001, 10'h00A, SLL, 1'b1, 10'h000};
    vecs[8]  = '{10'h005, 10'h003, SLT, 1'b1, 10'h000};
    vecs[9]  = '{10'h003, 10'h005, SLT, 1'b1, 10'h001};
    vecs[10] = '{10'h005, 10'h005, ADD, 1'b1, 10'h00A};
    vecs[11] = '{10'h012, 10'h034, LD,  1'b1, 10'h000};
    vecs[12] = '{10'h012, 10'h034, ADD, 1'b1, 10'h046};
    vecs[13] = '{10'h001, 10'h001, 4'b1111, 1'b0, 10'h046};
    vecs[14] = '{10'h002, 10'h003, SUB, 1'b1, 10'h3FF};

    // Reset, with strobes asserted to show reset priority.
    clr(); DIN = 10'h3FF; reset = 1;
    IR_in = 1; W_D = 1; incr_PC = 1; G_in = 1; ULA_control = ADD;
    step(); step();
    chk("reset_ir", IR, 10'h000);
    chk("reset_w", {9'b0, W}, 10'h000);
    chk("reset_addr", ADDR, 10'h000);
    chk("reset_dout", DOUT, 10'h000);
    chk("reset_gor", {9'b0, G_or}, 10'h000);
    read_sel("reset_pc", SEL_PC, 10'h000);
    read_sel("reset_g", SEL_G, 10'h000);
    read_reg("reset_r5", 3'd5, 10'h000);
    reset = 0;

    // PC load from DIN, wrap, and PC_in winning over incr_PC.
    clr(); DIN = 10'h155; PC_in = 1; step();
    read_sel("pc_load", SEL_PC, 10'h155);
    clr(); DIN = 10'h3FF; PC_in = 1; step();
    clr(); incr_PC = 1; step();
    read_sel("pc_wrap", SEL_PC, 10'h000);
    clr(); incr_PC = 1; step();
    read_sel("pc_incr", SEL_PC, 10'h001);
    clr(); DIN = 10'd40; PC_in = 1; incr_PC = 1; step();
    read_sel("pc_in_prio", SEL_PC, 10'd40);

    // Register-to-register SUB through A and the bus.
    load_reg(2, 10'd7);
    load_reg(3, 10'd5);
    clr(); mux_control = SEL_REG; register_out = 2; A_in = 1; step();
    clr(); mux_control = SEL_REG; register_out = 3; ULA_control = SUB; G_in = 1;
    #1;
    chk("ula_comb_sub", dut.ula_result, 10'd2);
    step();
    read_sel("sub_g", SEL_G, 10'd2);
    chk("sub_gor", {9'b0, G_or}, 10'd1);
    load_reg(3, 10'd7);
    clr(); mux_control = SEL_REG; register_out = 3; ULA_control = SUB; G_in = 1; step();
    read_sel("sub0_g", SEL_G, 10'd0);
    chk("sub0_gor", {9'b0, G_or}, 10'd0);

    // Store sequence: address, data and write enable line up.
    load_reg(1, 10'd20);
    load_reg(4, 10'd99);
    clr(); mux_control = SEL_REG; register_out = 1; ADDR_in = 1; step();
    clr(); mux_control = SEL_REG; register_out = 4; DOUT_in = 1; W_D = 1; step();
    clr();
    chk("st_addr", ADDR, 10'd20);
    chk("st_dout", DOUT, 10'd99);
    chk("st_w", {9'b0, W}, 10'd1);
    step();
    chk("st_w_low", {9'b0, W}, 10'd0);
    chk("st_dout_hold", DOUT, 10'd99);

    // Multi-register load and the empty register index.
    clr(); DIN = 10'd33; register_in = 7'b0000101; step();
    read_reg("multi_r0", 3'd0, 10'd33);
    read_reg("multi_r2", 3'd2, 10'd33);
    read_reg("multi_r1", 3'd1, 10'd20);
    read_reg("multi_r3", 3'd3, 10'd7);
    read_reg("multi_r4", 3'd4, 10'd99);
    read_reg("reg7_zero", 3'd7, 10'd0);

    // Read-during-write: bus shows the old value, new value next cycle.
    clr(); mux_control = SEL_REG; register_out = 0; ULA_control = 4'b1111;
    register_in = 7'b0000001; DIN = 10'h3AA;
    #1;
    chk("rdw_old", BusWires, 10'd33);
    mux_control = SEL_DIN;
    step();
    read_reg("rdw_new", 3'd0, 10'h3AA);

    // IR loads from DIN only.
    clr(); DIN = 10'h2AB; IR_in = 1; step();
    chk("ir_load", IR, 10'h2AB);

    // ULA vector table.
    foreach (vecs[i]) begin
      clr(); DIN = vecs[i].a; A_in = 1; step();
      clr(); DIN = vecs[i].b; ULA_control = vecs[i].op; G_in = vecs[i].g_in; step();
      read_sel($sformatf("ula_g[%0d]", i), SEL_G, vecs[i].exp_g);
      chk($sformatf("ula_gor[%0d]", i), {9'b0, G_or}, {9'b0, |vecs[i].exp_g});
    end

    // Reset mid-transfer discards the in-flight loads.
    clr(); DIN = 10'h0F0; A_in = 1; register_in = 7'b1111111; ULA_control = ADD;
    PC_in = 1; reset = 1; step();
    reset = 0;
    read_sel("mid_reset_g", SEL_G, 10'h000);
    chk("mid_reset_gor", {9'b0, G_or}, 10'd0);
    read_reg("mid_reset_r6", 3'd6, 10'h000);
    read_sel("mid_reset_pc", SEL_PC, 10'h000);
    clr(); DIN = 10'd1; ULA_control = ADD; G_in = 1; step();
    read_sel("mid_reset_a", SEL_G, 10'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

endmodule
